// File: rtl/sine_wave.sv
// sine_wave: direct digital synthesis sine generator.
//
// A 32-bit phase accumulator advances by PHASE_INC every clock. Its top eight
// bits select one of 256 phase steps per period; a 65-entry quarter-wave table
// plus quadrant folding turns that phase into a signed 16-bit sample.
//
// Parameters:
//   PHASE_INC  phase increment per clock (f_out = PHASE_INC * f_clk / 2^32)
//   AMPLITUDE  peak magnitude of sin_val, at most 32767
//
// Ports:
//   clk       system clock, rising-edge active
//   reset     asynchronous, active-high reset; clears every output
//   cnt       phase accumulator value
//   cnt_edge  high for the one cycle in which cnt holds a freshly wrapped value
//   sin_val   signed sine sample of the previous cycle's cnt (one clock behind)

module sine_wave #(
    parameter logic [31:0] PHASE_INC = 32'd214748,
    parameter int          AMPLITUDE = 32767
) (
    input  logic               clk,
    input  logic               reset,
    output logic [31:0]        cnt,
    output logic               cnt_edge,
    output logic signed [15:0] sin_val
);

    // Table entries are stored at full scale (32767) and rescaled at
    // elaboration. For the default amplitude the rescale is an identity, so the
    // entries are exactly round(32767 * sin(pi/2 * i/64)); for other amplitudes
    // the result lies within one LSB of the ideal rounded value.
    function automatic logic signed [15:0] scale(input int raw);
        return 16'((raw * AMPLITUDE + 16383) / 32767);
    endfunction

    logic [32:0]        sum;
    logic [7:0]         phase;
    logic [5:0]         k;
    logic [6:0]         idx;
    logic signed [15:0] mag;
    logic signed [15:0] sample;

    // The carry out of the 33-bit sum is exactly the wrap event.
    assign sum   = {1'b0, cnt} + {1'b0, PHASE_INC};
    assign phase = cnt[31:24];
    assign k     = phase[5:0];

    // Odd quadrants run the quarter table backwards (64-k, range 1..64).
    assign idx = phase[6] ? (7'd64 - {1'b0, k}) : {1'b0, k};

    // Quarter-wave ROM.
    always_comb begin
        mag = '0;
        case (idx)
            7'd0:  mag = scale(0);     7'd1:  mag = scale(804);
            7'd2:  mag = scale(1608);  7'd3:  mag = scale(2410);
            7'd4:  mag = scale(3212);  7'd5:  mag = scale(4011);
            7'd6:  mag = scale(4808);  7'd7:  mag = scale(5602);
            7'd8:  mag = scale(6393);  7'd9:  mag = scale(7179);
            7'd10: mag = scale(7962);  7'd11: mag = scale(8739);
            7'd12: mag = scale(9512);  7'd13: mag = scale(10278);
            7'd14: mag = scale(11039); 7'd15: mag = scale(11793);
            7'd16: mag = scale(12539); 7'd17: mag = scale(13279);
            7'd18: mag = scale(14010); 7'd19: mag = scale(14732);
            7'd20: mag = scale(15446); 7'd21: mag = scale(16151);
            7'd22: mag = scale(16846); 7'd23: mag = scale(17530);
            7'd24: mag = scale(18204); 7'd25: mag = scale(18868);
            7'd26: mag = scale(19519); 7'd27: mag = scale(20159);
            7'd28: mag = scale(20787); 7'd29: mag = scale(21403);
            7'd30: mag = scale(22005); 7'd31: mag = scale(22594);
            7'd32: mag = scale(23170); 7'd33: mag = scale(23731);
            7'd34: mag = scale(24279); 7'd35: mag = scale(24811);
            7'd36: mag = scale(25329); 7'd37: mag = scale(25832);
            7'd38: mag = scale(26319); 7'd39: mag = scale(26790);
            7'd40: mag = scale(27245); 7'd41: mag = scale(27683);
            7'd42: mag = scale(28105); 7'd43: mag = scale(28510);
            7'd44: mag = scale(28898); 7'd45: mag = scale(29268);
            7'd46: mag = scale(29621); 7'd47: mag = scale(29956);
            7'd48: mag = scale(30273); 7'd49: mag = scale(30571);
            7'd50: mag = scale(30852); 7'd51: mag = scale(31113);
            7'd52: mag = scale(31356); 7'd53: mag = scale(31580);
            7'd54: mag = scale(31785); 7'd55: mag = scale(31971);
            7'd56: mag = scale(32137); 7'd57: mag = scale(32285);
            7'd58: mag = scale(32412); 7'd59: mag = scale(32521);
            7'd60: mag = scale(32609); 7'd61: mag = scale(32678);
            7'd62: mag = scale(32728); 7'd63: mag = scale(32757);
            7'd64: mag = scale(32767);
            default: mag = '0;
        endcase
    end

    // Second half of the period is the negated first half. mag never exceeds
    // 32767, so the negation cannot overflow and -0 stays 0.
    assign sample = phase[7] ? -mag : mag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            cnt_edge <= 1'b0;
            sin_val  <= '0;
        end else begin
            cnt      <= sum[31:0];
            cnt_edge <= sum[32];
            sin_val  <= sample;
        end
    end

endmodule

// File: tb/tb_sine_wave.sv
// tb_sine_wave: self-checking bench for sine_wave.
//
// Three instances share clock and reset: the default increment, one phase
// step per clock (2^24) and a zero increment. A behavioural model computes
// the phase with 64-bit arithmetic and the sample directly from $sin.

module tb_sine_wave;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [31:0]        cnt_def, cnt_tbl, cnt_zero;
    logic               edge_def, edge_tbl, edge_zero;
    logic signed [15:0] sin_def, sin_tbl, sin_zero;

    // 10 MHz clock
    always #50 clk = ~clk;

    sine_wave #(.PHASE_INC(32'd214748)) u_def (
        .clk(clk), .reset(reset), .cnt(cnt_def), .cnt_edge(edge_def), .sin_val(sin_def)
    );
    sine_wave #(.PHASE_INC(32'h0100_0000)) u_tbl (
        .clk(clk), .reset(reset), .cnt(cnt_tbl), .cnt_edge(edge_tbl), .sin_val(sin_tbl)
    );
    sine_wave #(.PHASE_INC(32'd0)) u_zero (
        .clk(clk), .reset(reset), .cnt(cnt_zero), .cnt_edge(edge_zero), .sin_val(sin_zero)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    longint incs [3] = '{214748, 16777216, 0};
    longint ref_cnt [3];
    longint ref_edge [3];
    longint ref_sin [3];

    function automatic int ref_sample(input int p);
        real x;
        x = 32767.0 * $sin(2.0 * 3.14159265358979 * p / 256.0);
        if (x >= 0.0) return int'($floor(x + 0.5));
        else          return -int'($floor(-x + 0.5));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            ref_cnt[i]  = 0;
            ref_edge[i] = 0;
            ref_sin[i]  = 0;
        end
    endtask

    task automatic model_step();
        longint s;
        for (int i = 0; i < 3; i++) begin
            ref_sin[i]  = ref_sample(int'(ref_cnt[i] >> 24));
            s           = ref_cnt[i] + incs[i];
            ref_edge[i] = (s >= 64'h1_0000_0000) ? 1 : 0;
            ref_cnt[i]  = s % 64'h1_0000_0000;
        end
    endtask

    task automatic check_all();
        check("def_cnt",   {32'd0, cnt_def},  ref_cnt[0]);
        check("def_edge",  edge_def,          ref_edge[0]);
        check("def_sin",   sin_def,           ref_sin[0]);
        check("tbl_cnt",   {32'd0, cnt_tbl},  ref_cnt[1]);
        check("tbl_edge",  edge_tbl,          ref_edge[1]);
        check("tbl_sin",   sin_tbl,           ref_sin[1]);
        check("zero_cnt",  {32'd0, cnt_zero}, ref_cnt[2]);
        check("zero_edge", edge_zero,         ref_edge[2]);
        check("zero_sin",  sin_zero,          ref_sin[2]);
    endtask

    // ---------------- tracking ----------------
    int     cyc;
    int     first_def;
    longint first_def_cnt;
    int     last_tbl_edge;
    bit     capture_tbl;
    int     tbl_seen [256];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        check_all();
        if (edge_def && first_def == 0) begin
            first_def     = cyc;
            first_def_cnt = {32'd0, cnt_def};
        end
        if (edge_tbl) begin
            check("tbl_edge_period", cyc - last_tbl_edge, 256);
            last_tbl_edge = cyc;
        end
        if (capture_tbl && cyc >= 1 && cyc <= 256) tbl_seen[cyc - 1] = sin_tbl;
    endtask

    // Called at a falling edge: asserts reset between clock edges and checks
    // the outputs have cleared before the next rising edge.
    task automatic async_reset(input int delay_ns);
        #(delay_ns);
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
    endtask

    task automatic hold_reset(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic release_reset();
        reset         = 1'b0;
        cyc           = 0;
        first_def     = 0;
        first_def_cnt = 0;
        last_tbl_edge = 0;
    endtask

    task automatic check_first_edge(input string tag);
        check({tag, "_cnt"},  {32'd0, cnt_def}, 214748);
        check({tag, "_sin"},  sin_def,          0);
        check({tag, "_edge"}, edge_def,         0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int mx, mn;
        model_reset();
        capture_tbl = 1'b0;
        #1;
        check_all();
        @(negedge clk);
        hold_reset(2);
        release_reset();
        capture_tbl = 1'b1;

        // first edge after release, then run through the first wrap
        tick();
        check_first_edge("rst_first");
        repeat (20001) tick();
        capture_tbl = 1'b0;
        check("def_first_wrap_cycle", first_def, 20001);
        check("def_wrap_cnt", first_def_cnt, 207452);
        check("def_edge_after_wrap", edge_def, 0);

        // table shape at selected phases
        check("tbl_p0",   tbl_seen[0],   0);
        check("tbl_p1",   tbl_seen[1],   804);
        check("tbl_p64",  tbl_seen[64],  32767);
        check("tbl_p128", tbl_seen[128], 0);
        check("tbl_p192", tbl_seen[192], -32767);
        check("tbl_p255", tbl_seen[255], -804);

        // symmetry over the whole period
        mx = -40000;
        mn = 40000;
        for (int p = 0; p < 256; p++) begin
            if (tbl_seen[p] > mx) mx = tbl_seen[p];
            if (tbl_seen[p] < mn) mn = tbl_seen[p];
            check($sformatf("sym_neg_p%0d", p), tbl_seen[p], -tbl_seen[(p + 128) % 256]);
            if (p != 64 && p != 192)
                check($sformatf("sym_mirror_p%0d", p), tbl_seen[p], tbl_seen[(128 - p) & 255]);
        end
        check("tbl_max", mx, 32767);
        check("tbl_min", mn, -32767);

        // zero increment stayed idle throughout
        check("zero_cnt_final", {32'd0, cnt_zero}, 0);
        check("zero_sin_final", sin_zero, 0);

        // mid-run asynchronous reset at cycle 5000
        async_reset(10);
        hold_reset(2);
        release_reset();
        repeat (5000) tick();
        async_reset(20);
        check("mid_rst_cnt",  {32'd0, cnt_def}, 0);
        check("mid_rst_edge", edge_def, 0);
        check("mid_rst_sin",  sin_def, 0);
        hold_reset(2);
        release_reset();
        tick();
        check_first_edge("mid_first");

        // randomized run lengths and reset timing
        repeat (15) begin
            repeat ($urandom_range(800, 20)) tick();
            async_reset($urandom_range(40, 5));
            hold_reset($urandom_range(3, 1));
            release_reset();
            tick();
            check_first_edge("rnd_first");
        end
        repeat (300) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
